wb_arm_phase_ctrl: RTL

- Parametrised AHB slave-side phase controller; next generation of the team's address/data phase tracker.
- Accepts AHB address phases and registers the address/control for the data phase.
- Inserts a configurable number of wait states, stretches further on a back-end ready, and drives ahb_hready_out/ahb_hresp, including the two-cycle ERROR response.
- Sits between the AHB slave mux and the Wishbone-side bridge logic; supports pipelined back-to-back transfers.

---
 rtl/wb_arm_phase_ctrl_if.sv | 35 +++
 rtl/wb_arm_phase_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/wb_arm_phase_ctrl_if.sv
// wb_arm_phase_ctrl_if: AHB slave-side address/data phase signal bundle.
// The master modport drives the bus side; the slave modport is the controller.
interface wb_arm_phase_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  ahb_hsel;
    logic                  ahb_hready_in;
    logic [1:0]            ahb_htrans;
    logic [ADDR_WIDTH-1:0] ahb_haddr;
    logic                  ahb_hwrite;
    logic [2:0]            ahb_hsize;
    logic                  ext_ready;
    logic                  ahb_hready_out;
    logic [1:0]            ahb_hresp;
    logic                  ahb_data_phase;
    logic [ADDR_WIDTH-1:0] dp_addr;
    logic                  dp_write;
    logic [2:0]            dp_size;
    logic                  dp_done;
    logic                  fsm_error;

    modport slave (
        input  ahb_hsel, ahb_hready_in, ahb_htrans, ahb_haddr,
        input  ahb_hwrite, ahb_hsize, ext_ready,
        output ahb_hready_out, ahb_hresp, ahb_data_phase,
        output dp_addr, dp_write, dp_size, dp_done, fsm_error
    );

    modport master (
        output ahb_hsel, ahb_hready_in, ahb_htrans, ahb_haddr,
        output ahb_hwrite, ahb_hsize, ext_ready,
        input  ahb_hready_out, ahb_hresp, ahb_data_phase,
        input  dp_addr, dp_write, dp_size, dp_done, fsm_error
    );
endinterface

// File: rtl/wb_arm_phase_ctrl.sv
// wb_arm_phase_ctrl: AHB slave address/data phase tracker with wait states.
// Define WB_ARM_PHASE_ERR_RESP_EN for the two-cycle ERROR on haddr >= ADDR_LIMIT.
module wb_arm_phase_ctrl #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    CNT_WIDTH   = 4,
    parameter int                    WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT  = 'h0001_0000
) (
    input logic                ahb_hclk,
    input logic                ahb_hreset,
    wb_arm_phase_ctrl_if.slave bus
);
    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_WAIT  = 6'b000010,
        S_DATA  = 6'b000100,
        S_ERR1  = 6'b001000,
        S_ERR2  = 6'b010000,
        S_ERROR = 6'b100000
    } state_e;

    localparam logic [CNT_WIDTH-1:0] WS_LOAD = CNT_WIDTH'(WAIT_STATES - 1);

    logic [5:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] dp_addr_q;
    logic                  dp_write_q;
    logic [2:0]            dp_size_q;
    logic                  accept;
    logic                  addr_err;
    logic [5:0]            dec_state;
    logic [CNT_WIDTH-1:0]  dec_cnt;
    logic                  unused_ok;

    assign accept = bus.ahb_hsel & bus.ahb_hready_in & bus.ahb_htrans[1];

`ifdef WB_ARM_PHASE_ERR_RESP_EN
    assign addr_err  = bus.ahb_haddr >= ADDR_LIMIT;
    assign unused_ok = bus.ahb_htrans[0];
    assign bus.ahb_hresp = (state_q == S_ERR1 || state_q == S_ERR2)
                         ? 2'b01 : 2'b00;
`else
    assign addr_err  = 1'b0;
    assign unused_ok = ^{bus.ahb_htrans[0], ADDR_LIMIT};
    assign bus.ahb_hresp = 2'b00;
`endif

    // Where a new transfer goes; shared by IDLE, completing DATA and ERR2.
    always_comb begin
        dec_state = S_IDLE;
        dec_cnt   = cnt_q;
        if (accept) begin
            if (addr_err) begin
                dec_state = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                dec_state = S_WAIT;
                dec_cnt   = WS_LOAD;
            end else begin
                dec_state = S_DATA;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_ERR2: begin
                state_d = dec_state;
                cnt_d   = dec_cnt;
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_DATA;
                else             cnt_d   = cnt_q - CNT_WIDTH'(1);
            end
            S_DATA: begin
                if (bus.ext_ready) begin
                    state_d = dec_state;
                    cnt_d   = dec_cnt;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_ERROR;
        endcase
    end

    always_ff @(posedge ahb_hclk or negedge ahb_hreset) begin
        if (!ahb_hreset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dp_addr_q  <= '0;
            dp_write_q <= 1'b0;
            dp_size_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                dp_addr_q  <= bus.ahb_haddr;
                dp_write_q <= bus.ahb_hwrite;
                dp_size_q  <= bus.ahb_hsize;
            end
        end
    end

    // Illegal encodings fall through to the default-high HREADY.
    assign bus.ahb_hready_out = !(state_q == S_WAIT || state_q == S_ERR1)
                             && (state_q != S_DATA || bus.ext_ready);
    assign bus.ahb_data_phase = (state_q == S_WAIT) || (state_q == S_DATA);
    assign bus.dp_done        = (state_q == S_DATA) && bus.ext_ready;
    assign bus.fsm_error      = (state_q == S_ERROR);
    assign bus.dp_addr        = dp_addr_q;
    assign bus.dp_write       = dp_write_q;
    assign bus.dp_size        = dp_size_q;
endmodule
